// File: rtl/chip8_seq_pkg.sv
// rtl/chip8_seq_pkg.sv - shared states, opcode constants and step decode for the Chip-8 fetch sequencer
package chip8_seq_pkg;

  localparam logic [11:0] DEFAULT_START_ADDR = 12'h200;

  // Sequencer states; BREAK only exists when the breakpoint feature is built in
  typedef enum logic [2:0] {
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_WAIT_KEY,
    S_HALT
`ifdef CHIP8_SEQ_BREAKPOINT_EN
    , S_BREAK
`endif
  } seq_state_t;

  // Top nibble of the opcode
  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_JP   = 4'h1;
  localparam logic [3:0] OP_CALL = 4'h2;
  localparam logic [3:0] OP_SE   = 4'h3;
  localparam logic [3:0] OP_SNE  = 4'h4;
  localparam logic [3:0] OP_SEV  = 4'h5;
  localparam logic [3:0] OP_JPV0 = 4'hB;
  localparam logic [3:0] OP_SKP  = 4'hE;
  localparam logic [3:0] OP_F    = 4'hF;

  // Low byte selectors for the Fxkk and Exkk groups
  localparam logic [7:0] F_LDK   = 8'h0A;
  localparam logic [7:0] F_BCD   = 8'h33;
  localparam logic [7:0] F_STR   = 8'h55;
  localparam logic [7:0] F_LDR   = 8'h65;
  localparam logic [7:0] E_SKP   = 8'h9E;
  localparam logic [7:0] E_SKNP  = 8'hA1;

  localparam logic [11:0] SYS_RET = 12'h0EE;

  // Index of the final execute step for an opcode (0 for single-cycle ops)
  function automatic logic [3:0] exec_last_step(input logic [15:0] op);
    logic [3:0] last;
    last = 4'd0;
    if (op[15:12] == OP_F) begin
      if (op[7:0] == F_STR || op[7:0] == F_LDR) last = op[11:8];
      else if (op[7:0] == F_BCD) last = 4'd2;
    end
    return last;
  endfunction

endpackage

// File: rtl/chip8_fetch_sequencer_if.sv
// rtl/chip8_fetch_sequencer_if.sv - dual-port opcode fetch bus between sequencer and byte memory
interface chip8_fetch_sequencer_if;
  logic [11:0] mem_addr_hi;
  logic [11:0] mem_addr_lo;
  logic [7:0]  mem_rddata_hi;
  logic [7:0]  mem_rddata_lo;

  modport master (
    output mem_addr_hi,
    output mem_addr_lo,
    input  mem_rddata_hi,
    input  mem_rddata_lo
  );

  modport slave (
    input  mem_addr_hi,
    input  mem_addr_lo,
    output mem_rddata_hi,
    output mem_rddata_lo
  );
endinterface

// File: rtl/chip8_call_stack.sv
// rtl/chip8_call_stack.sv - 12-bit return-address LIFO with full/empty flags
module chip8_call_stack #(
  parameter int STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [11:0] push_data,
  output logic [11:0] top,
  output logic        full,
  output logic        empty
);

  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  logic [SPW-1:0] sp;
  logic [11:0]    entries [STACK_DEPTH];
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;

  assign wr_idx = sp[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign top    = entries[rd_idx];
  assign full   = (sp == SPW'(STACK_DEPTH));
  assign empty  = (sp == '0);

  // Stack pointer; overflowing pushes and underflowing pops are ignored here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  // Entry storage needs no reset: only slots below sp are ever read
  always_ff @(posedge clk) begin
    if (push && !full) entries[wr_idx] <= push_data;
  end

endmodule

// File: rtl/chip8_fetch_sequencer.sv
// rtl/chip8_fetch_sequencer.sv - Chip-8 PC/stack/IR sequencer; optional breakpoint via CHIP8_SEQ_BREAKPOINT_EN
module chip8_fetch_sequencer
  import chip8_seq_pkg::*;
#(
  parameter logic [11:0] START_ADDR  = DEFAULT_START_ADDR,
  parameter int          STACK_DEPTH = 16
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        run,
  chip8_fetch_sequencer_if.master mem,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic [3:0]  control,
  input  logic [7:0]  vx_data,
  input  logic [7:0]  vy_data,
  input  logic [7:0]  v0_data,
  input  logic [15:0] keys,
  output logic [3:0]  key_index,
  output logic [11:0] pc,
  output logic        halted,
  output logic        stack_err
`ifdef CHIP8_SEQ_BREAKPOINT_EN
  ,
  input  logic        bp_en,
  input  logic [11:0] bp_addr,
  input  logic        bp_resume,
  output logic        bp_hit
`endif
);

  seq_state_t  state;

  logic [15:0] fetched;
  logic        f_is_call;
  logic        f_is_ret;
  logic        f_is_ldk;
  logic        stack_fault;

  logic [3:0]  op;
  logic [11:0] nnn;
  logic [7:0]  kk;
  logic        is_call;
  logic        is_ret;
  logic [3:0]  last_step;
  logic        exec_done;
  logic        key_sel;
  logic [11:0] next_pc;
  logic [3:0]  low_key;

  logic        stk_push;
  logic        stk_pop;
  logic [11:0] stk_top;
  logic        stk_full;
  logic        stk_empty;

  assign mem.mem_addr_hi = pc;
  assign mem.mem_addr_lo = pc + 12'd1;

  // Stack faults are caught while the opcode is still on the memory bus, so a
  // faulting call/return never raises instr_valid
  assign fetched     = {mem.mem_rddata_hi, mem.mem_rddata_lo};
  assign f_is_call   = (fetched[15:12] == OP_CALL);
  assign f_is_ret    = (fetched[15:12] == OP_SYS) && (fetched[11:0] == SYS_RET);
  assign f_is_ldk    = (fetched[15:12] == OP_F) && (fetched[7:0] == F_LDK);
  assign stack_fault = (f_is_call && stk_full) || (f_is_ret && stk_empty);

  assign op        = instruction[15:12];
  assign nnn       = instruction[11:0];
  assign kk        = instruction[7:0];
  assign is_call   = (op == OP_CALL);
  assign is_ret    = (op == OP_SYS) && (nnn == SYS_RET);
  assign last_step = exec_last_step(instruction);
  assign exec_done = (state == S_EXEC) && (control == last_step);
  assign key_sel   = keys[vx_data[3:0]];

  assign stk_push  = exec_done && is_call && !stk_full;
  assign stk_pop   = exec_done && is_ret && !stk_empty;

  chip8_call_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (cpu_clk),
    .rst_n     (reset_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc + 12'd2),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Control-flow resolution for the instruction currently in the execute window
  always_comb begin
    next_pc = pc + 12'd2;
    case (op)
      OP_JP, OP_CALL: next_pc = nnn;
      OP_SYS:  if (is_ret) next_pc = stk_top;
      OP_JPV0: next_pc = nnn + {4'h0, v0_data};
      OP_SE:   if (vx_data == kk) next_pc = pc + 12'd4;
      OP_SNE:  if (vx_data != kk) next_pc = pc + 12'd4;
      OP_SEV:  if (instruction[3:0] == 4'h0 && vx_data == vy_data) next_pc = pc + 12'd4;
      OP_SKP: begin
        if ((kk == E_SKP && key_sel) || (kk == E_SKNP && !key_sel)) next_pc = pc + 12'd4;
      end
      default: next_pc = pc + 12'd2;
    endcase
  end

  // Lowest pressed key wins when several are held
  always_comb begin
    low_key = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (keys[i]) low_key = 4'(i);
    end
  end

  // Main sequencer FSM with all outputs registered
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      pc          <= START_ADDR;
      instruction <= 16'h0000;
      instr_valid <= 1'b0;
      control     <= 4'd0;
      key_index   <= 4'd0;
      halted      <= 1'b0;
      stack_err   <= 1'b0;
`ifdef CHIP8_SEQ_BREAKPOINT_EN
      bp_hit      <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (run) begin
`ifdef CHIP8_SEQ_BREAKPOINT_EN
            if (bp_en && pc == bp_addr) begin
              bp_hit <= 1'b1;
              state  <= S_BREAK;
            end else begin
              state  <= S_LATCH;
            end
`else
            state <= S_LATCH;
`endif
          end
        end
        S_LATCH: begin
          instruction <= fetched;
          if (stack_fault) begin
            stack_err <= 1'b1;
            halted    <= 1'b1;
            state     <= S_HALT;
          end else if (f_is_ldk) begin
            state <= S_WAIT_KEY;
          end else begin
            instr_valid <= 1'b1;
            control     <= 4'd0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (control == last_step) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            control     <= 4'd0;
            state       <= S_FETCH;
          end else begin
            control <= control + 4'd1;
          end
        end
        S_WAIT_KEY: begin
          if (|keys) begin
            key_index   <= low_key;
            instr_valid <= 1'b1;
            control     <= 4'd0;
            state       <= S_EXEC;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
`ifdef CHIP8_SEQ_BREAKPOINT_EN
        // Resume goes straight to LATCH so the same PC cannot re-trigger
        S_BREAK: begin
          if (bp_resume) begin
            bp_hit <= 1'b0;
            state  <= S_LATCH;
          end
        end
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// tb/tb_chip8_fetch_sequencer.sv - vector table plus scoreboard bench for chip8_fetch_sequencer
module tb_chip8_fetch_sequencer;

  logic        cpu_clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [3:0]  control;
  logic [7:0]  vx_data, vy_data, v0_data;
  logic [15:0] keys;
  logic [3:0]  key_index;
  logic [11:0] pc;
  logic        halted;
  logic        stack_err;

  logic [7:0]  memory [4096];

  int n_cmp = 0;
  int n_err = 0;

  chip8_fetch_sequencer_if bus();

  chip8_fetch_sequencer dut (
    .cpu_clk     (cpu_clk),
    .reset_n     (reset_n),
    .run         (run),
    .mem         (bus),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .control     (control),
    .vx_data     (vx_data),
    .vy_data     (vy_data),
    .v0_data     (v0_data),
    .keys        (keys),
    .key_index   (key_index),
    .pc          (pc),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Byte memory with one-cycle synchronous read on both ports
  always @(posedge cpu_clk) begin
    bus.mem_rddata_hi <= memory[bus.mem_addr_hi];
    bus.mem_rddata_lo <= memory[bus.mem_addr_lo];
  end

  typedef struct {
    logic [15:0] op;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [7:0]  v0;
    logic [15:0] keys;
    int          steps;
    logic [11:0] npc;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    int          steps;
    logic [11:0] npc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) memory[i] = 8'h00;
  endtask

  task automatic put_op(input logic [11:0] addr, input logic [15:0] op);
    logic [11:0] a1;
    a1 = addr + 12'd1;
    memory[addr] = op[15:8];
    memory[a1]   = op[7:0];
  endtask

  task automatic hold_reset();
    @(negedge cpu_clk);
    reset_n = 1'b0;
    run     = 1'b0;
    @(negedge cpu_clk);
  endtask

  // Waits (bounded) for instr_valid; returns negedges elapsed, 0 on timeout
  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    do begin
      @(negedge cpu_clk);
      n++;
    end while (!instr_valid && n < 60);
    lat = instr_valid ? n : 0;
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge cpu_clk);
      if (instr_valid) cnt++;
    end
  endtask

  vec_t vecs[17];

  initial begin
    int   lat, k, cnt;
    exp_t e;

    vecs[0]  = '{16'h6A05, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 12'h202};
    vecs[1]  = '{16'h3A05, 8'h05, 8'h00, 8'h00, 16'h0000, 1, 12'h204};
    vecs[2]  = '{16'h3A05, 8'h06, 8'h00, 8'h00, 16'h0000, 1, 12'h202};
    vecs[3]  = '{16'h4A05, 8'h06, 8'h00, 8'h00, 16'h0000, 1, 12'h204};
    vecs[4]  = '{16'h4A05, 8'h05, 8'h00, 8'h00, 16'h0000, 1, 12'h202};
    vecs[5]  = '{16'h5AB0, 8'h07, 8'h07, 8'h00, 16'h0000, 1, 12'h204};
    vecs[6]  = '{16'h5AB0, 8'h07, 8'h08, 8'h00, 16'h0000, 1, 12'h202};
    vecs[7]  = '{16'h5AB1, 8'h07, 8'h07, 8'h00, 16'h0000, 1, 12'h202};
    vecs[8]  = '{16'h1ABC, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 12'hABC};
    vecs[9]  = '{16'hB123, 8'h00, 8'h00, 8'h10, 16'h0000, 1, 12'h133};
    vecs[10] = '{16'hBFF0, 8'h00, 8'h00, 8'h20, 16'h0000, 1, 12'h010};
    vecs[11] = '{16'hE19E, 8'h03, 8'h00, 8'h00, 16'h0008, 1, 12'h204};
    vecs[12] = '{16'hE1A1, 8'h03, 8'h00, 8'h00, 16'h0008, 1, 12'h202};
    vecs[13] = '{16'hF355, 8'h00, 8'h00, 8'h00, 16'h0000, 4, 12'h202};
    vecs[14] = '{16'hF265, 8'h00, 8'h00, 8'h00, 16'h0000, 3, 12'h202};
    vecs[15] = '{16'hF033, 8'h00, 8'h00, 8'h00, 16'h0000, 3, 12'h202};
    vecs[16] = '{16'hFFFF, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 12'h202};

    reset_n = 1'b0;
    run     = 1'b0;
    vx_data = 8'h00;
    vy_data = 8'h00;
    v0_data = 8'h00;
    keys    = 16'h0000;
    clear_mem();
    repeat (3) @(negedge cpu_clk);

    check("reset_pc", 32'(pc), 32'h200);
    check("reset_instruction", 32'(instruction), 32'h0);
    check("reset_instr_valid", 32'(instr_valid), 32'h0);
    check("reset_control", 32'(control), 32'h0);
    check("reset_key_index", 32'(key_index), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_stack_err", 32'(stack_err), 32'h0);

    // Table-driven single-instruction vectors, each from a fresh reset at 0x200
    for (int v = 0; v < 17; v++) begin
      hold_reset();
      clear_mem();
      put_op(12'h200, vecs[v].op);
      vx_data = vecs[v].vx;
      vy_data = vecs[v].vy;
      v0_data = vecs[v].v0;
      keys    = vecs[v].keys;
      sb.push_back('{vecs[v].op, vecs[v].steps, vecs[v].npc});
      @(negedge cpu_clk);
      reset_n = 1'b1;
      run     = 1'b1;
      wait_valid(lat);
      e = sb.pop_front();
      check($sformatf("latency_%0h", e.instr), 32'(lat), 32'd2);
      check($sformatf("instr_%0h", e.instr), 32'(instruction), 32'(e.instr));
      k = 0;
      while (instr_valid && k < 20) begin
        check($sformatf("control_%0h_step%0d", e.instr, k), 32'(control), 32'(k));
        k++;
        @(negedge cpu_clk);
      end
      run = 1'b0;
      check($sformatf("valid_cycles_%0h", e.instr), 32'(k), 32'(e.steps));
      check($sformatf("next_pc_%0h", e.instr), 32'(pc), 32'(e.npc));
    end

    // Call then return
    hold_reset();
    clear_mem();
    put_op(12'h200, 16'h2300);
    put_op(12'h300, 16'h00EE);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    run     = 1'b1;
    wait_valid(lat);
    check("call_instr", 32'(instruction), 32'h2300);
    @(negedge cpu_clk);
    check("call_pc", 32'(pc), 32'h300);
    check("call_sp", 32'(dut.u_stack.sp), 32'd1);
    wait_valid(lat);
    check("ret_instr", 32'(instruction), 32'h00EE);
    @(negedge cpu_clk);
    run = 1'b0;
    check("ret_pc", 32'(pc), 32'h202);
    check("ret_sp", 32'(dut.u_stack.sp), 32'd0);

    // Seventeen nested calls overflow the 16-deep stack
    hold_reset();
    clear_mem();
    put_op(12'h200, 16'h2200);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    run     = 1'b1;
    count_valid(120, cnt);
    check("overflow_valid_count", 32'(cnt), 32'd16);
    check("overflow_halted", 32'(halted), 32'h1);
    check("overflow_stack_err", 32'(stack_err), 32'h1);
    check("overflow_pc", 32'(pc), 32'h200);

    // Return with an empty stack
    hold_reset();
    clear_mem();
    put_op(12'h200, 16'h00EE);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    run     = 1'b1;
    count_valid(20, cnt);
    check("underflow_valid_count", 32'(cnt), 32'd0);
    check("underflow_halted", 32'(halted), 32'h1);
    check("underflow_stack_err", 32'(stack_err), 32'h1);
    check("underflow_pc", 32'(pc), 32'h200);

    // run=0 holds at FETCH; dropping run mid multicycle op lets it finish
    hold_reset();
    clear_mem();
    put_op(12'h200, 16'hF355);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    count_valid(8, cnt);
    check("paused_valid_count", 32'(cnt), 32'd0);
    check("paused_pc", 32'(pc), 32'h200);
    run = 1'b1;
    wait_valid(lat);
    check("resume_latency", 32'(lat), 32'd2);
    @(negedge cpu_clk);
    run = 1'b0;
    k = 1;
    while (instr_valid && k < 20) begin
      k++;
      @(negedge cpu_clk);
    end
    check("midop_valid_cycles", 32'(k), 32'd4);
    check("midop_pc", 32'(pc), 32'h202);
    count_valid(6, cnt);
    check("midop_no_reissue", 32'(cnt), 32'd0);

    // 12-bit wrap of the low-byte address
    hold_reset();
    clear_mem();
    put_op(12'h200, 16'h1FFF);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    run     = 1'b1;
    wait_valid(lat);
    run = 1'b0;
    @(negedge cpu_clk);
    check("wrap_addr_hi", 32'(bus.mem_addr_hi), 32'hFFF);
    check("wrap_addr_lo", 32'(bus.mem_addr_lo), 32'h000);

    // Key wait: nothing issues until a key appears, lowest key wins
    hold_reset();
    clear_mem();
    put_op(12'h200, 16'h1204);
    put_op(12'h204, 16'hF50A);
    keys = 16'h0000;
    @(negedge cpu_clk);
    reset_n = 1'b1;
    run     = 1'b1;
    count_valid(16, cnt);
    check("keywait_valid_count", 32'(cnt), 32'd1);
    check("keywait_pc", 32'(pc), 32'h204);
    keys = 16'h0028;
    wait_valid(lat);
    check("key_latency", 32'(lat), 32'd1);
    check("key_index", 32'(key_index), 32'd3);
    check("key_instr", 32'(instruction), 32'hF50A);
    @(negedge cpu_clk);
    run  = 1'b0;
    keys = 16'h0000;
    check("key_valid_one_cycle", 32'(instr_valid), 32'h0);
    check("key_next_pc", 32'(pc), 32'h206);

    // Asynchronous reset while waiting for a key
    hold_reset();
    @(negedge cpu_clk);
    reset_n = 1'b1;
    run     = 1'b1;
    repeat (14) @(negedge cpu_clk);
    check("midwait_pc", 32'(pc), 32'h204);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_pc", 32'(pc), 32'h200);
    check("async_reset_instruction", 32'(instruction), 32'h0);
    check("async_reset_valid", 32'(instr_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
